inst_mem_loader: RTL and testbench

- Writer-side counterpart of the instruction fetch path. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the instruction memory write port at consecutive word addresses starting at 0.
- Holds the fetch unit in reset while loading, so the CPU starts from PC=0 on a freshly written program.
- Produces a completion pulse and a running 32-bit checksum for host-side confirmation.

---
 rtl/inst_mem_loader_pkg.sv | 24 ++
 rtl/inst_mem_loader_if.sv | 39 +++
 rtl/inst_mem_loader.sv | 104 ++++++++++
 tb/tb_inst_mem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader_pkg
//  Brief    : Shared constants and state encoding for the instruction memory
//             loader and the fetch unit that reads the same memory.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_mem_loader_pkg;

  // Instruction memory geometry, shared with the fetch unit
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader_if
//  Brief    : Instruction stream handshake plus instruction memory write port.
//             master = stream source / memory side, slave = loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader
//  Brief    : Streams instruction words into the instruction memory at word
//             addresses 0..N-1, holds the CPU in reset while loading, and
//             reports completion with a done pulse and a running checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     load_len,
  inst_mem_loader_if.slave    bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum
);

  // Full memory depth expressed in the (ADDR_W+1)-bit length domain
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  load_state_t      state;
  logic [ADDR_W:0]  count;
  logic [ADDR_W:0]  len_q;
  logic [ADDR_W:0]  len_clamped;
  logic             handshake;

  // Ready is a pure decode of the LOAD state so the source sees it in-cycle
  assign bus.in_ready = (state == ST_LOAD);
  assign handshake    = bus.in_valid & bus.in_ready;
  assign len_clamped  = (load_len > DEPTH) ? DEPTH : load_len;

  // Load FSM with counter, checksum and registered memory write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      len_q         <= '0;
      checksum      <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            checksum <= '0;
            count    <= '0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            if (load_len == '0) begin
              // Empty program: skip straight to completion
              len_q <= '0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              len_q <= len_clamped;
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= count[ADDR_W-1:0];
            bus.mem_wdata <= bus.in_data;
            count         <= count + 1'b1;
            checksum      <= checksum + bus.in_data;
            if (count == len_q - 1'b1) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Final write is on the port this cycle; completion follows
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Brief    : Self-checking bench for inst_mem_loader. A word-list model
//             predicts every memory write, the checksum and the
//             hold/busy/done timeline of each load.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  int vectors;
  int errors;

  logic [DATA_W-1:0] words [0:DEPTH-1];

  inst_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle outputs after a completed load
  task automatic check_idle(input string tag, input logic [DATA_W-1:0] exp_sum);
    check({tag, "_busy"},  busy,         1'b0);
    check({tag, "_hold"},  cpu_hold,     1'b0);
    check({tag, "_done"},  done,         1'b0);
    check({tag, "_rdy"},   bus.in_ready, 1'b0);
    check({tag, "_we"},    bus.mem_we,   1'b0);
    check({tag, "_sum"},   checksum,     exp_sum);
  endtask

  // One complete load. vmode: 0 valid always, 1 valid pattern 1,0,0, 2 random.
  // noise: random start/load_len activity during the load, which must be ignored.
  task automatic run_load(input int len, input int vmode, input bit noise);
    int eff;
    int i;
    int cyc;
    bit v;
    logic [DATA_W-1:0] sum;
    eff = (len > DEPTH) ? DEPTH : len;
    @(negedge clk);
    bus.in_valid = 1'b0;
    start        = 1'b1;
    load_len     = len[ADDR_W:0];
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      check("zero_done", done,       1'b1);
      check("zero_we",   bus.mem_we, 1'b0);
      check("zero_sum",  checksum,   '0);
      check("zero_hold", cpu_hold,   1'b1);
      check("zero_busy", busy,       1'b1);
      @(negedge clk);
      check_idle("zero_idle", '0);
      return;
    end
    check("ld_busy", busy,     1'b1);
    check("ld_hold", cpu_hold, 1'b1);
    check("ld_done", done,     1'b0);
    sum = '0;
    i   = 0;
    cyc = 0;
    while (i < eff) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((cyc % 3) == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? words[i] : $urandom;
      if (noise) begin
        start    = ($urandom_range(0, 3) == 0);
        load_len = $urandom;
      end
      check("ld_rdy", bus.in_ready, 1'b1);
      @(negedge clk);
      check("ld_we", bus.mem_we, v);
      if (v) begin
        check("ld_addr",  bus.mem_addr,  i[ADDR_W-1:0]);
        check("ld_wdata", bus.mem_wdata, words[i]);
        sum = sum + words[i];
        i++;
      end
      cyc++;
    end
    // FLUSH: final write visible, stream closed
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    start        = 1'b0;
    check("fl_rdy",  bus.in_ready, 1'b0);
    check("fl_done", done,         1'b0);
    check("fl_hold", cpu_hold,     1'b1);
    @(negedge clk);
    // DONE: completion pulse
    check("dn_done", done,       1'b1);
    check("dn_we",   bus.mem_we, 1'b0);
    check("dn_hold", cpu_hold,   1'b1);
    check("dn_sum",  checksum,   sum);
    @(negedge clk);
    check_idle("post", sum);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    rst          = 1'b0;
    start        = 1'b1;
    load_len     = 7'd4;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;

    // Reset held for two cycles with noisy inputs
    repeat (2) @(negedge clk);
    check_idle("rst", '0);
    check("rst_addr",  bus.mem_addr,  '0);
    check("rst_wdata", bus.mem_wdata, '0);
    rst   = 1'b1;
    start = 1'b0;

    // IDLE ignores the stream entirely
    repeat (3) begin
      bus.in_data = $urandom;
      @(negedge clk);
      check_idle("idle", '0);
    end
    bus.in_valid = 1'b0;

    // Short program, valid held high, then with a sparse valid pattern
    words[0] = 32'h20010005;
    words[1] = 32'h20020003;
    words[2] = 32'h00221820;
    words[3] = 32'hAC030000;
    run_load(4, 0, 1'b0);
    run_load(4, 1, 1'b0);

    // Full depth with word value = address, then an over-length request
    for (int k = 0; k < DEPTH; k++) words[k] = k;
    run_load(64, 0, 1'b0);
    check("full_sum", checksum, 32'd2016);
    run_load(100, 2, 1'b0);
    check("clamp_sum", checksum, 32'd2016);

    // Empty program
    run_load(0, 0, 1'b0);

    // Randomised loads with random stalls and ignored start activity
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < DEPTH; k++) words[k] = $urandom;
      run_load($urandom_range(1, 80), 2, 1'b1);
    end

    // Reset mid-load after two words, with an ignored start in between
    for (int k = 0; k < DEPTH; k++) words[k] = $urandom;
    @(negedge clk);
    start    = 1'b1;
    load_len = 7'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[k];
      @(negedge clk);
      check("mr_addr", bus.mem_addr, k[ADDR_W-1:0]);
    end
    bus.in_valid = 1'b0;
    start        = 1'b1;
    load_len     = 7'd1;
    @(negedge clk);
    start = 1'b0;
    check("mr_stall_we", bus.mem_we,   1'b0);
    check("mr_busy",     busy,         1'b1);
    check("mr_rdy",      bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = words[2];
    @(negedge clk);
    check("mr_cont_we",    bus.mem_we,    1'b1);
    check("mr_cont_addr",  bus.mem_addr,  6'd2);
    check("mr_cont_wdata", bus.mem_wdata, words[2]);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("mr_rst", '0);
    repeat (3) begin
      @(negedge clk);
      check_idle("mr_after", '0);
    end

    // Recovery: a normal load after the abandoned one
    run_load(5, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
